// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte-wide UART transmitter (8N1, LSB first, idle-high)
// fed through a small circular FIFO, so bursty producers are decoupled from
// the serial bit rate.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is sent between the data bits and the stop
//                bit (11-bit frame)
//   undefined -> plain 8N1 (10-bit frame)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   data_in     byte to transmit
//   data_valid  data_in is valid this cycle
//   data_ready  FIFO can take a byte this cycle
//   tx          serial line output (registered, idle high)
//   busy        a frame is in flight or bytes are still queued
//   fifo_level  current FIFO occupancy
//
// Handshake: a byte is taken on the rising edge where data_valid && data_ready.
// data_ready is a flop that mirrors "FIFO not full". It has no combinational
// path from data_valid. The producer must hold data_valid (and data_in) until
// it sees data_ready.
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 125000000,
    parameter int BAUD_RATE  = 230400,
    parameter int BIT_TIME   = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BIT_TIME) + 1;

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_TIME - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    // FIFO storage. It has no reset: the pointers and the level define which
    // entries are valid.
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ready_q, ready_d;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic       push;
    logic       pop;
    logic       bit_done;
    logic [7:0] head;

    assign push     = data_valid && ready_q;
    assign bit_done = (cnt_q == BIT_LAST);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        // The baud counter runs in every non-idle state and wraps at BIT_TIME.
        if (state_q == IDLE || bit_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop       = 1'b1;
                    state_d   = START;
                    bit_idx_d = '0;
                    shift_d   = head;
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when more bytes
                    // are queued, so back-to-back frames have no idle gap.
                    if (level_q != '0) begin
                        pop       = 1'b1;
                        state_d   = START;
                        bit_idx_d = '0;
                        shift_d   = head;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_TX_PARITY_EN
        // Even parity over the data byte, latched when the byte leaves the FIFO.
        parity_d = pop ? ^head : parity_q;
`endif

        // tx follows the registered state. This gives the one-cycle
        // pop-to-start-bit latency, and every bit lasts exactly BIT_TIME cycles.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        ready_d = (level_d != FULL_LEVEL);

        // Including state_q keeps busy high until the tx flop has finished
        // driving the last stop bit. tx lags the state by one cycle.
        busy_d = (level_d != '0) || (state_d != IDLE) || (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ready_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ready_q   <= ready_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign data_ready = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

endmodule
